// File: rtl/regfile_arb_pkg.sv
// Shared widths and the register-file write request type used by the write-port arbiter.
package regfile_arb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_wr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle for the write-port arbiter: write-back request, MDU handshake, decode hazard query, RF port.
interface regfile_write_arbiter_if;
  import regfile_arb_pkg::*;

  logic                  WB_WE;
  logic [REG_ADDR_W-1:0] WB_A;
  logic [DATA_W-1:0]     WB_WD;
  // MDU handshake: a result transfers on a rising edge where MDU_Valid && MDU_Ready;
  // MDU_Ready never depends on MDU_Valid, and the MDU must hold its payload until it transfers.
  logic                  MDU_Valid;
  logic [REG_ADDR_W-1:0] MDU_A;
  logic [DATA_W-1:0]     MDU_WD;
  logic                  MDU_Ready;
  logic [REG_ADDR_W-1:0] Dec_Rs;
  logic [REG_ADDR_W-1:0] Dec_Rt;
  logic [REG_ADDR_W-1:0] Dec_Rd;
  logic                  Stall_Pending;
  logic                  Stall_Starve;
  logic                  WE3;
  logic [REG_ADDR_W-1:0] A3;
  logic [DATA_W-1:0]     WD3;

  modport slave (
    input  WB_WE, WB_A, WB_WD, MDU_Valid, MDU_A, MDU_WD, Dec_Rs, Dec_Rt, Dec_Rd,
    output MDU_Ready, Stall_Pending, Stall_Starve, WE3, A3, WD3
  );
  modport master (
    output WB_WE, WB_A, WB_WD, MDU_Valid, MDU_A, MDU_WD, Dec_Rs, Dec_Rt, Dec_Rd,
    input  MDU_Ready, Stall_Pending, Stall_Starve, WE3, A3, WD3
  );
endinterface

// File: rtl/wrarb_fifo.sv
// MDU result buffer: circular FIFO with registered occupancy and a per-entry valid/address view.
module wrarb_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  push,
  input  logic                                  pop,
  input  rf_wr_req_t                            in_req,
  output rf_wr_req_t                            head,
  output logic                                  full,
  output logic                                  empty,
  output logic [DEPTH-1:0]                      ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      ent_addr
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  rf_wr_req_t    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; stale slots are masked by ent_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= in_req;
  end

  // An entry is live when its distance from the read pointer is below occupancy.
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_ptr_q;
      ent_valid[i] = ({1'b0, off} < count_q);
      ent_addr[i]  = mem_q[i].addr;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: write-back priority, buffered MDU drain, decode hazard flag.
// Optional starvation stall is built when WRARB_STARVE_GUARD_EN is defined.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     CLK_WrArb,
  input  logic                     RST_WrArb,
  regfile_write_arbiter_if.slave   bus
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("regfile_write_arbiter: bad DEPTH or STARVE_LIMIT");
  end

  rf_wr_req_t                         in_req, head;
  logic                               full, empty, push, pop;
  logic [DEPTH-1:0]                   ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_addr;
  logic                               mdu_ready;
  logic                               pending;

  // Zero-address results complete the handshake but are dropped.
  assign mdu_ready = RST_WrArb && !full;
  assign push      = bus.MDU_Valid && mdu_ready && (bus.MDU_A != REG_ZERO);
  assign pop       = RST_WrArb && !bus.WB_WE && !empty;
  assign in_req    = '{addr: bus.MDU_A, data: bus.MDU_WD};

  wrarb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK_WrArb),
    .rst_n     (RST_WrArb),
    .push      (push),
    .pop       (pop),
    .in_req    (in_req),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  always_comb begin
    bus.WE3 = 1'b0;
    bus.A3  = REG_ZERO;
    bus.WD3 = '0;
    if (RST_WrArb) begin
      if (bus.WB_WE) begin
        bus.WE3 = 1'b1;
        bus.A3  = bus.WB_A;
        bus.WD3 = bus.WB_WD;
      end else if (!empty) begin
        bus.WE3 = 1'b1;
        bus.A3  = head.addr;
        bus.WD3 = head.data;
      end
    end
  end

  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] &&
          ((bus.Dec_Rs != REG_ZERO && ent_addr[i] == bus.Dec_Rs) ||
           (bus.Dec_Rt != REG_ZERO && ent_addr[i] == bus.Dec_Rt) ||
           (bus.Dec_Rd != REG_ZERO && ent_addr[i] == bus.Dec_Rd)))
        pending = 1'b1;
    end
  end

  assign bus.MDU_Ready     = mdu_ready;
  assign bus.Stall_Pending = RST_WrArb && pending;

`ifdef WRARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starve_q, starve_d;

  // Count cycles the buffer is held off by write-back; any pop or empty buffer restarts it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (empty || pop)
      starve_cnt_d = '0;
    else if (bus.WB_WE && starve_cnt_q != SW'(STARVE_LIMIT))
      starve_cnt_d = starve_cnt_q + 1'b1;
    starve_d = pop ? 1'b0 : (starve_q || (starve_cnt_d == SW'(STARVE_LIMIT)));
  end

  always_ff @(posedge CLK_WrArb or negedge RST_WrArb) begin
    if (!RST_WrArb) begin
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign bus.Stall_Starve = RST_WrArb && starve_q;
`else
  assign bus.Stall_Starve = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, scoreboarded drain sequences, reset mid-drain.
module tb_regfile_write_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus();

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK_WrArb (clk),
    .RST_WrArb (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_a;
    logic [31:0] wb_wd;
    logic        mdu_v;
    logic [4:0]  mdu_a;
    logic [31:0] mdu_wd;
    logic [4:0]  rs, rt, rd;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd3;
    logic        e_rdy;
    logic        e_pend;
  } vec_t;

  vec_t        vecs[12];
  logic [36:0] exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          m_cnt  = 0;
  logic        m_starve = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wb_we, input logic [4:0] wb_a, input logic [31:0] wb_wd,
                       input logic mdu_v, input logic [4:0] mdu_a, input logic [31:0] mdu_wd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.WB_WE = wb_we;  bus.WB_A = wb_a;   bus.WB_WD = wb_wd;
    bus.MDU_Valid = mdu_v; bus.MDU_A = mdu_a; bus.MDU_WD = mdu_wd;
    bus.Dec_Rs = rs; bus.Dec_Rt = rt; bus.Dec_Rd = rd;
  endtask

  // Checks one cycle against the queue model, then advances the model at the edge.
  task automatic check_cycle(input string tag);
    logic        e_rdy, e_pend, e_we, do_pop;
    logic [4:0]  e_a3;
    logic [31:0] e_wd3;
    @(negedge clk);
    e_rdy  = (exp_q.size() < DEPTH);
    e_pend = 1'b0;
    foreach (exp_q[i]) begin
      if ((bus.Dec_Rs != 0 && exp_q[i][36:32] == bus.Dec_Rs) ||
          (bus.Dec_Rt != 0 && exp_q[i][36:32] == bus.Dec_Rt) ||
          (bus.Dec_Rd != 0 && exp_q[i][36:32] == bus.Dec_Rd)) e_pend = 1'b1;
    end
    do_pop = !bus.WB_WE && exp_q.size() > 0;
    if (bus.WB_WE) begin
      e_we = 1'b1; e_a3 = bus.WB_A; e_wd3 = bus.WB_WD;
    end else if (do_pop) begin
      e_we = 1'b1; e_a3 = exp_q[0][36:32]; e_wd3 = exp_q[0][31:0];
    end else begin
      e_we = 1'b0; e_a3 = 5'd0; e_wd3 = 32'd0;
    end
    chk({tag, "_rdy"},  {31'd0, bus.MDU_Ready},     {31'd0, e_rdy});
    chk({tag, "_pend"}, {31'd0, bus.Stall_Pending}, {31'd0, e_pend});
    chk({tag, "_we"},   {31'd0, bus.WE3},           {31'd0, e_we});
    chk({tag, "_a3"},   {27'd0, bus.A3},            {27'd0, e_a3});
    chk({tag, "_wd3"},  bus.WD3,                    e_wd3);
`ifdef WRARB_STARVE_GUARD_EN
    chk({tag, "_starve"}, {31'd0, bus.Stall_Starve}, {31'd0, m_starve});
`else
    chk({tag, "_starve"}, {31'd0, bus.Stall_Starve}, 32'd0);
`endif
    @(posedge clk);
    if (exp_q.size() == 0 || do_pop) m_cnt = 0;
    else if (bus.WB_WE && m_cnt < STARVE_LIMIT) m_cnt++;
    m_starve = do_pop ? 1'b0 : (m_starve || m_cnt == STARVE_LIMIT);
    if (do_pop) void'(exp_q.pop_front());
    if (bus.MDU_Valid && e_rdy && bus.MDU_A != 0) exp_q.push_back({bus.MDU_A, bus.MDU_WD});
    #1;
  endtask

  initial begin
    //           wb_we wb_a wb_wd        mv mdu_a mdu_wd      rs rt rd  we a3  wd3          rdy pend
    vecs[0]  = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,      1'b1, 1'b0};
    vecs[1]  = '{1'b1, 5'd3, 32'h11,     1'b0, 5'd0,  32'h0,      5'd0, 5'd0, 5'd0, 1'b1, 5'd3,  32'h11,     1'b1, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,      1'b1, 5'd5,  32'hAAAA,   5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,      1'b1, 1'b0};
    vecs[3]  = '{1'b1, 5'd7, 32'h77,     1'b0, 5'd0,  32'h0,      5'd0, 5'd5, 5'd0, 1'b1, 5'd7,  32'h77,     1'b1, 1'b1};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      5'd0, 5'd0, 5'd0, 1'b1, 5'd5,  32'hAAAA,   1'b1, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      5'd0, 5'd0, 5'd5, 1'b0, 5'd0,  32'h0,      1'b1, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,      1'b1, 5'd0,  32'h1234,   5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,      1'b1, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,      1'b1, 1'b0};
    vecs[8]  = '{1'b1, 5'd0, 32'hDEAD,   1'b1, 5'd9,  32'h99,     5'd0, 5'd0, 5'd0, 1'b1, 5'd0,  32'hDEAD,   1'b1, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,      1'b1, 5'd10, 32'h10,     5'd9, 5'd0, 5'd0, 1'b1, 5'd9,  32'h99,     1'b1, 1'b1};
    vecs[10] = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      5'd9, 5'd0, 5'd0, 1'b1, 5'd10, 32'h10,     1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,      1'b1, 1'b0};

    // Reset state: outputs forced low even with a write-back request present.
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'h55, 1'b1, 5'd4, 32'h66, 5'd4, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we",     {31'd0, bus.WE3}, 32'd0);
    chk("rst_a3",     {27'd0, bus.A3}, 32'd0);
    chk("rst_wd3",    bus.WD3, 32'd0);
    chk("rst_rdy",    {31'd0, bus.MDU_Ready}, 32'd0);
    chk("rst_pend",   {31'd0, bus.Stall_Pending}, 32'd0);
    chk("rst_starve", {31'd0, bus.Stall_Starve}, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].wb_we, vecs[i].wb_a, vecs[i].wb_wd, vecs[i].mdu_v, vecs[i].mdu_a,
            vecs[i].mdu_wd, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d_we", i),   {31'd0, bus.WE3},           {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_a3", i),   {27'd0, bus.A3},            {27'd0, vecs[i].e_a3});
      chk($sformatf("v%0d_wd3", i),  bus.WD3,                    vecs[i].e_wd3);
      chk($sformatf("v%0d_rdy", i),  {31'd0, bus.MDU_Ready},     {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_pend", i), {31'd0, bus.Stall_Pending}, {31'd0, vecs[i].e_pend});
      @(posedge clk); #1;
    end

    // Fill under write-back pressure; the fifth offer must be refused, then drain in order.
    for (int k = 0; k < DEPTH + 1; k++) begin
      drive(1'b1, 5'd1, $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0, 5'd0, 5'd0);
      check_cycle($sformatf("fill%0d", k));
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < DEPTH + 1; k++) check_cycle($sformatf("drain%0d", k));
    chk("full_drained", exp_q.size(), 32'd0);

    // Starvation: one entry held off by write-back for STARVE_LIMIT cycles, then popped.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0DE, 5'd0, 5'd0, 5'd0);
    check_cycle("st_push");
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 5'd0);
      check_cycle($sformatf("st_hold%0d", k));
    end
`ifdef WRARB_STARVE_GUARD_EN
    chk("starve_set", {31'd0, bus.Stall_Starve}, 32'd1);
`else
    chk("starve_off", {31'd0, bus.Stall_Starve}, 32'd0);
`endif
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 5'd0);
    check_cycle("st_pop");
    chk("starve_clr", {31'd0, bus.Stall_Starve}, 32'd0);
    check_cycle("st_idle");

    // Random traffic against the queue model.
    for (int k = 0; k < 200; k++) begin
      drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      check_cycle($sformatf("rnd%0d", k));
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < DEPTH + 1; k++) check_cycle($sformatf("rnd_drain%0d", k));

    // Reset mid-drain: three entries buffered, one popped, reset lands mid-cycle.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'(k + 2), 32'hB0 + 32'(k), 5'd0, 5'd0, 5'd0);
      check_cycle($sformatf("rd_fill%0d", k));
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd0);
    check_cycle("rd_pop");
    #3 rst_n = 1'b0;
    #1;
    chk("rd_we",   {31'd0, bus.WE3}, 32'd0);
    chk("rd_a3",   {27'd0, bus.A3}, 32'd0);
    chk("rd_wd3",  bus.WD3, 32'd0);
    chk("rd_rdy",  {31'd0, bus.MDU_Ready}, 32'd0);
    chk("rd_pend", {31'd0, bus.Stall_Pending}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_cnt = 0;
    m_starve = 1'b0;
    check_cycle("rd_post0");
    check_cycle("rd_post1");
    drive(1'b1, 5'd6, 32'h600D, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    check_cycle("rd_wb");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbitrates the single register-file write port (WE3/A3/WD3) between the pipeline write-back stage and a long-latency multiply/divide unit (MDU). Write-back always wins. MDU results are buffered in a small FIFO and drained into idle write-port cycles. The block also flags decode-stage hazards against buffered, not-yet-committed results, so the pipeline can stall.

## Interface
Parameters:
- DEPTH, 4: MDU result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8: consecutive blocked cycles before a starvation stall (used only with the guard macro)

Ports:
- CLK_WrArb  in  1  clock; everything samples on rising edge
- RST_WrArb  in  1  reset, asynchronous, active-low
- WB_WE  in  1  write-back write request
- WB_A  in  5  write-back destination
- WB_WD  in  32  write-back data
- MDU_Valid  in  1  MDU result offered
- MDU_A  in  5  MDU destination
- MDU_WD  in  32  MDU data
- MDU_Ready  out  1  FIFO accepts an entry this cycle
- Dec_Rs, Dec_Rt, Dec_Rd  in  5 each  decode-stage source and destination addresses
- Stall_Pending  out  1  a decode address matches a buffered entry
- Stall_Starve  out  1  starvation stall request
- WE3  out  1  register-file write enable
- A3  out  5  register-file write address
- WD3  out  32  register-file write data

## Operation
- Enqueue when MDU_Valid && MDU_Ready.
- An MDU_A of 0 is accepted as a handshake but discarded; no entry is created.
- MDU_Ready = !full, where full comes from registered occupancy.
- When full, no enqueue occurs, even if a dequeue happens in the same cycle.
- Port mux, combinational, with fixed priority:
  - WB_WE=1: WE3=1, A3=WB_A, WD3=WB_WD.
  - Else if the FIFO is non-empty: WE3=1, A3/WD3 come from the FIFO head, and the head is popped at the edge.
  - Else WE3=0, A3=0, WD3=0.
- A write-back to address 0 still drives the port; the register file ignores it. The FIFO does not drain that cycle.
- Hazard check: Stall_Pending=1 if any valid entry's address equals a non-zero Dec_Rs, Dec_Rt or Dec_Rd.
  - The entry being popped this cycle still counts.
  - Address 0 never matches.
- Occupancy counter is 0..DEPTH, log2(DEPTH)+1 bits wide.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.
- On simultaneous push and pop (not full), occupancy is unchanged and both pointers advance.

## Timing
- Write-back path: 0-cycle latency, pure pass-through.
- MDU path: enqueued at edge N; earliest write to the register file is at edge N+1, provided WB_WE=0 in cycle N+1.
- Stall_Pending, MDU_Ready and WE3/A3/WD3 are combinational from registered state and current inputs.
- Stall_Starve is registered.
- Reset, asserted asynchronously at any time, including mid-drain:
  - FIFO is flushed: occupancy 0, pointers 0, starve counter 0.
  - While reset is low: WE3=0, A3=0, WD3=0, MDU_Ready=0, Stall_Pending=0, Stall_Starve=0. All outputs are forced.
- First cycle after reset release: MDU_Ready=1 and WE3 follows WB_WE.

## Configuration
Macro: WRARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments each cycle with FIFO non-empty && WB_WE=1.
  - It clears on any cycle that pops the FIFO, and whenever the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, Stall_Starve is set at that edge.
  - Stall_Starve stays set until the edge at which a pop occurs.
  - The counter saturates at STARVE_LIMIT.
- Undefined: no counter is built and Stall_Starve is tied to 0.

## Structure
- Package regfile_arb_pkg holds:
  - REG_ADDR_W=5 and DATA_W=32
  - typedef rf_wr_req_t {addr, data}
  - REG_ZERO=5'd0
- Sub-module wrarb_fifo, parameterized by DEPTH:
  - Ports: push, pop, in/head rf_wr_req_t, full, empty, plus a per-entry valid/address vector for the hazard compare.
- The top level holds the priority mux, the hazard comparators and the starvation guard.

## Test plan
- Reset mid-drain: enqueue 3 entries, assert RST_WrArb low mid-cycle → WE3=0 immediately; after release MDU_Ready=1, no stale writes, Stall_Pending=0.
- Drain with priority: push {A=5, D=0xAAAA} at edge 0, WB_WE=1 {A=7} in cycle 1, WB_WE=0 in cycle 2 → cycle 1 writes A3=7, cycle 2 writes A3=5/WD3=0xAAAA, cycle 3 WE3=0.
- Full: with WB_WE held 1, push DEPTH entries → MDU_Ready=0; a 5th MDU_Valid is not accepted; once WB_WE=0, entries drain in FIFO order and MDU_Ready=1 in the cycle after the first pop.
- Hazard: entry A=9 buffered, Dec_Rt=9 → Stall_Pending=1; Dec_Rs=Dec_Rt=Dec_Rd=0 → 0; after the pop edge → 0.
- Zero address: MDU_Valid with A=0 → MDU_Ready=1, occupancy remains 0, no write.
- Starvation (macro defined): 1 entry buffered, WB_WE=1 for 8 cycles → Stall_Starve=1 after the 8th edge; WB_WE=0 → pop, and Stall_Starve=0 at that edge. Macro undefined → Stall_Starve always 0.
